// File: rtl/nco_pkg.sv
// Shared definitions for the NCO sweep controller: FSM state encoding and default widths.
package nco_pkg;

  localparam int NCO_PHASE_W = 32;
  localparam int NCO_DWELL_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DWELL = 2'd2,
    S_STEP  = 2'd3
  } sweep_state_t;

endpackage

// File: rtl/nco_sweep_step.sv
// Combinational next-tuning-word calculation: direction, add/sub with carry/borrow,
// clamp to f_stop so the word never wraps, and end-of-sweep flag.
module nco_sweep_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] f_start,
  input  logic [W-1:0] f_stop,
  input  logic [W-1:0] f_step,
  output logic [W-1:0] next,
  output logic         at_end
);

  logic [W:0] sum_s;
  logic [W:0] diff_s;

  assign sum_s  = {1'b0, cur} + {1'b0, f_step};
  assign diff_s = {1'b0, cur} - {1'b0, f_step};
  assign at_end = (cur == f_stop);

  // A zero step would otherwise stall, so it jumps straight to the stop word.
  always_comb begin
    next = f_stop;
    if (f_step == '0) begin
      next = f_stop;
    end else if (f_stop >= f_start) begin
      if (sum_s[W] || (sum_s[W-1:0] > f_stop)) begin
        next = f_stop;
      end else begin
        next = sum_s[W-1:0];
      end
    end else begin
      if (diff_s[W] || (diff_s[W-1:0] < f_stop)) begin
        next = f_stop;
      end else begin
        next = diff_s[W-1:0];
      end
    end
  end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep controller feeding the NCO phase increment.
// Define NCO_SWEEP_TRIANGLE_EN for ping-pong (triangle) loop mode; default loop is sawtooth.
module nco_sweep_ctrl
  import nco_pkg::*;
#(
  parameter int PHASE_W = NCO_PHASE_W,
  parameter int DWELL_W = NCO_DWELL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               loop_en,
  input  logic [PHASE_W-1:0] f_start,
  input  logic [PHASE_W-1:0] f_stop,
  input  logic [PHASE_W-1:0] f_step,
  input  logic [DWELL_W-1:0] dwell,
  output logic [PHASE_W-1:0] phase_inc,
  output logic               busy,
  output logic               done
);

  sweep_state_t       state_r, state_s;
  logic [PHASE_W-1:0] sh_start_r, sh_stop_r, sh_step_r, phase_inc_r;
  logic [PHASE_W-1:0] calc_start_s, calc_stop_s, next_s;
  logic [DWELL_W-1:0] sh_dwell_r, cnt_r, reload_s;
  logic               sh_loop_r, busy_r, done_r;
  logic               step_end_s, at_end_s, swap_s;

  assign reload_s = (sh_dwell_r == '0) ? '0 : (sh_dwell_r - DWELL_W'(1));

`ifdef NCO_SWEEP_TRIANGLE_EN
  // End detection uses the unswapped stop word; on a looping end the step sees swapped bounds.
  assign at_end_s     = (phase_inc_r == sh_stop_r);
  assign swap_s       = at_end_s && sh_loop_r;
  assign calc_start_s = swap_s ? sh_stop_r  : sh_start_r;
  assign calc_stop_s  = swap_s ? sh_start_r : sh_stop_r;
`else
  assign at_end_s     = step_end_s;
  assign swap_s       = 1'b0;
  assign calc_start_s = sh_start_r;
  assign calc_stop_s  = sh_stop_r;
`endif

  nco_sweep_step #(.W(PHASE_W)) u_step (
    .cur     (phase_inc_r),
    .f_start (calc_start_s),
    .f_stop  (calc_stop_s),
    .f_step  (sh_step_r),
    .next    (next_s),
    .at_end  (step_end_s)
  );

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_s = state_r;
    if (abort) begin
      state_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE:  state_s = start ? S_LOAD : S_IDLE;
        S_LOAD:  state_s = S_DWELL;
        S_DWELL: state_s = (cnt_r == '0) ? S_STEP : S_DWELL;
        S_STEP: begin
          if (!at_end_s) begin
            state_s = S_DWELL;
          end else if (swap_s) begin
            state_s = S_DWELL;
          end else if (sh_loop_r) begin
            state_s = S_LOAD;
          end else begin
            state_s = S_IDLE;
          end
        end
        default: state_s = S_IDLE;
      endcase
    end
  end

  // State, status flags, shadow registers, dwell counter and tuning word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      sh_start_r  <= '0;
      sh_stop_r   <= '0;
      sh_step_r   <= '0;
      sh_dwell_r  <= '0;
      sh_loop_r   <= 1'b0;
      cnt_r       <= '0;
      phase_inc_r <= '0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != S_IDLE);
      done_r  <= !abort && (state_r == S_STEP) && at_end_s && !sh_loop_r;
      if (!abort) begin
        case (state_r)
          S_IDLE: begin
            if (start) begin
              sh_start_r <= f_start;
              sh_stop_r  <= f_stop;
              sh_step_r  <= f_step;
              sh_dwell_r <= dwell;
              sh_loop_r  <= loop_en;
            end
          end
          S_LOAD: begin
            phase_inc_r <= sh_start_r;
            cnt_r       <= reload_s;
          end
          S_DWELL: begin
            if (cnt_r != '0) begin
              cnt_r <= cnt_r - DWELL_W'(1);
            end
          end
          S_STEP: begin
            if (!at_end_s || swap_s) begin
              phase_inc_r <= next_s;
              cnt_r       <= reload_s;
            end
            if (swap_s) begin
              sh_start_r <= sh_stop_r;
              sh_stop_r  <= sh_start_r;
            end
          end
          default: begin
            cnt_r <= '0;
          end
        endcase
      end
    end
  end

  assign phase_inc = phase_inc_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl: table-driven single-shot sweeps plus
// hand-written abort, loop and reset sequences, checked cycle by cycle from a queue.
module tb_nco_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, loop_en;
  logic [31:0] f_start, f_stop, f_step;
  logic [15:0] dwell;
  logic [31:0] phase_inc;
  logic        busy, done;

  typedef struct {
    logic [31:0] phase;
    logic        busy;
    logic        done;
  } exp_t;

  typedef struct {
    logic [31:0] fs;
    logic [31:0] fe;
    logic [31:0] st;
    logic [15:0] dw;
    int          n;
    logic [31:0] w [4];
  } vec_t;

  exp_t        sb[$];
  vec_t        vt[6];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_word = 32'd0;

  always #5 clk = ~clk;

  nco_sweep_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .loop_en   (loop_en),
    .f_start   (f_start),
    .f_stop    (f_stop),
    .f_step    (f_step),
    .dwell     (dwell),
    .phase_inc (phase_inc),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] p, input logic b, input logic d, input int n);
    for (int i = 0; i < n; i++) sb.push_back('{phase: p, busy: b, done: d});
  endtask

  // Consume the scoreboard one cycle at a time; inputs are scrambled after the
  // first edge to show the sweep only uses the values latched at start.
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      @(posedge clk);
      #1;
      start   = 1'b0;
      abort   = 1'b0;
      f_start = $urandom;
      f_stop  = $urandom;
      f_step  = $urandom;
      dwell   = 16'($urandom_range(0, 7));
      loop_en = 1'($urandom_range(0, 1));
      e = sb.pop_front();
      chk("phase_inc", phase_inc, e.phase);
      chk("busy", {31'd0, busy}, {31'd0, e.busy});
      chk("done", {31'd0, done}, {31'd0, e.done});
    end
  endtask

  task automatic kick(input logic [31:0] fs, input logic [31:0] fe, input logic [31:0] st,
                      input logic [15:0] dw, input logic le);
    f_start = fs;
    f_stop  = fe;
    f_step  = st;
    dwell   = dw;
    loop_en = le;
    abort   = 1'b0;
    start   = 1'b1;
  endtask

  task automatic set_vec(input int i, input logic [31:0] fs, input logic [31:0] fe,
                         input logic [31:0] st, input logic [15:0] dw, input int n,
                         input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [31:0] w3);
    vt[i].fs = fs; vt[i].fe = fe; vt[i].st = st; vt[i].dw = dw; vt[i].n = n;
    vt[i].w[0] = w0; vt[i].w[1] = w1; vt[i].w[2] = w2; vt[i].w[3] = w3;
  endtask

  task automatic run_single(input int i);
    int d;
    d = (vt[i].dw == 16'd0) ? 1 : int'(vt[i].dw);
    kick(vt[i].fs, vt[i].fe, vt[i].st, vt[i].dw, 1'b0);
    push(last_word, 1'b1, 1'b0, 1);
    for (int k = 0; k < vt[i].n; k++) push(vt[i].w[k], 1'b1, 1'b0, d + 1);
    last_word = vt[i].w[vt[i].n - 1];
    push(last_word, 1'b0, 1'b1, 1);
    push(last_word, 1'b0, 1'b0, 1);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_vec(0, 32'd100, 32'd130, 32'd10, 16'd2, 4, 32'd100, 32'd110, 32'd120, 32'd130);
    set_vec(1, 32'd0, 32'd25, 32'd10, 16'd2, 4, 32'd0, 32'd10, 32'd20, 32'd25);
    set_vec(2, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd1, 2,
            32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd0, 32'd0);
    set_vec(3, 32'd50, 32'd20, 32'd15, 16'd2, 3, 32'd50, 32'd35, 32'd20, 32'd0);
    set_vec(4, 32'd50, 32'd20, 32'd0, 16'd0, 2, 32'd50, 32'd20, 32'd0, 32'd0);
    set_vec(5, 32'd7, 32'd7, 32'd5, 16'd3, 1, 32'd7, 32'd0, 32'd0, 32'd0);

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; loop_en = 1'b0;
    f_start = 32'd0; f_stop = 32'd0; f_step = 32'd0; dwell = 16'd0;
    #12;
    chk("reset_phase_inc", phase_inc, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_single(i);

    // Abort at the dwell midpoint of word 110, with a simultaneous start.
    kick(32'd100, 32'd130, 32'd10, 16'd2, 1'b0);
    push(last_word, 1'b1, 1'b0, 1);
    push(32'd100, 1'b1, 1'b0, 3);
    push(32'd110, 1'b1, 1'b0, 2);
    drain();
    abort = 1'b1;
    start = 1'b1;
    push(32'd110, 1'b0, 1'b0, 3);
    drain();
    last_word = 32'd110;

    // Continuous loop, then abort.
    kick(32'd100, 32'd130, 32'd10, 16'd2, 1'b1);
    push(last_word, 1'b1, 1'b0, 1);
`ifdef NCO_SWEEP_TRIANGLE_EN
    push(32'd100, 1'b1, 1'b0, 3);
    push(32'd110, 1'b1, 1'b0, 3);
    push(32'd120, 1'b1, 1'b0, 3);
    push(32'd130, 1'b1, 1'b0, 3);
    push(32'd120, 1'b1, 1'b0, 3);
    push(32'd110, 1'b1, 1'b0, 3);
    push(32'd100, 1'b1, 1'b0, 3);
    push(32'd110, 1'b1, 1'b0, 3);
    last_word = 32'd110;
`else
    for (int p = 0; p < 2; p++) begin
      push(32'd100, 1'b1, 1'b0, 3);
      push(32'd110, 1'b1, 1'b0, 3);
      push(32'd120, 1'b1, 1'b0, 3);
      push(32'd130, 1'b1, 1'b0, 4);
    end
    push(32'd100, 1'b1, 1'b0, 3);
    last_word = 32'd100;
`endif
    drain();
    abort = 1'b1;
    push(last_word, 1'b0, 1'b0, 2);
    drain();

    // Asynchronous reset mid-dwell, then a fresh sweep.
    kick(32'd100, 32'd130, 32'd10, 16'd2, 1'b0);
    push(last_word, 1'b1, 1'b0, 1);
    push(32'd100, 1'b1, 1'b0, 3);
    push(32'd110, 1'b1, 1'b0, 1);
    drain();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_phase_inc", phase_inc, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_word = 32'd0;
    run_single(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nco_sweep_ctrl.md
# nco_sweep_ctrl

Frequency-sweep controller that drives the 32-bit `phase_inc` input of the NCO directly upstream of it. On `start` it steps the tuning word from a start to a stop frequency in fixed increments, holding each word for a programmable dwell time. It supports single-shot and continuous loop modes, which produce linear chirps and stepped-tone test signals for the FMC streaming path. All control inputs come from the register bank in the same clock domain.

## Interface
- `PHASE_W`, default 32: tuning-word width; must match the NCO accumulator width.
- `DWELL_W`, default 16: dwell-counter width.

- `clk`  in  1: system clock, the same clock as the NCO.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: single-cycle request; honoured only in IDLE.
- `abort`  in  1: stops the sweep; takes priority over everything except reset.
- `loop_en`  in  1: repeat the sweep continuously.
- `f_start`  in  PHASE_W: first tuning word.
- `f_stop`  in  PHASE_W: last tuning word.
- `f_step`  in  PHASE_W: unsigned step magnitude.
- `dwell`  in  DWELL_W: cycles each word is held; a value of 0 is treated as 1.
- `phase_inc`  out  PHASE_W: registered tuning word to the NCO.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when a single-shot sweep completes.

## Operation
- States: IDLE, LOAD, DWELL, STEP.
- IDLE:
  - `phase_inc` holds its last value.
  - On `start`, `f_start`, `f_stop`, `f_step`, `dwell` and `loop_en` are latched into shadow registers, and the FSM goes to LOAD.
  - Input changes after this point have no effect until the next `start`.
- LOAD: `phase_inc` <= shadow `f_start`; the dwell counter is set to max(dwell,1)-1; the FSM goes to DWELL.
- DWELL: the counter decrements every cycle. At 0, the FSM goes to STEP.
- STEP, when the current word equals `f_stop` (end of sweep):
  - If `loop_en` is set: go to LOAD, or apply the triangle behaviour (see Configuration).
  - Otherwise: pulse `done` and go to IDLE.
- STEP, in all other cases:
  - Compute the next word with PHASE_W+1-bit arithmetic.
  - Direction is up if `f_stop` >= `f_start`, and down otherwise.
  - Up: next = cur + step. If next > `f_stop` or the carry bit is set, clamp to `f_stop`.
  - Down: next = cur - step. If next < `f_stop` or a borrow occurs, clamp to `f_stop`.
  - Load `phase_inc` with next, reload the dwell counter, and go to DWELL.
- The tuning word never wraps; clamping guarantees `f_stop` is always output for one full dwell.
- `f_step` = 0 jumps straight to `f_stop` on the first STEP.
- `f_start` = `f_stop`: one word, one dwell, then end of sweep.
- `abort` in any state:
  - Next state is IDLE.
  - `phase_inc` keeps its current value.
  - No `done` pulse.
  - Abort and start in the same cycle: abort wins.
- `start` while `busy` is ignored.

## Timing
- Reset values: `phase_inc` = 0, `busy` = 0, `done` = 0, state IDLE, and all shadow registers 0.
- `start` sampled in cycle T:
  - `busy` = 1 from T+1.
  - `phase_inc` = `f_start` from T+2.
- Each word, including the first and the last, is present for exactly max(dwell,1) + 1 cycles. The extra cycle is the LOAD or STEP cycle in which the word is computed.
- The new word appears on `phase_inc` in the cycle after STEP.
- For the final word, `done` and the fall of `busy` occur in the same cycle, 1 cycle after the dwell expires.
- Loop restart: `f_start` reappears 2 cycles after the last dwell expires (STEP, then LOAD).
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset asserted mid-sweep returns every output to its reset value immediately, asynchronously.

## Configuration
- `NCO_SWEEP_TRIANGLE_EN` defined:
  - Loop mode ping-pongs: on reaching `f_stop`, the shadow `f_start` and `f_stop` are swapped internally and the sweep continues from the current word in the opposite direction.
  - Going through LOAD is skipped, so `f_stop` is output once, not twice.
- Undefined: loop mode is sawtooth only, restarting from `f_start`; swap logic is absent.
- Single-shot behaviour is identical in both builds.

## Structure
- The shared package `nco_pkg` holds:
  - the FSM state typedef (`sweep_state_t`);
  - `NCO_PHASE_W` = 32, which sets the PHASE_W default;
  - the dwell-width constant.
- Natural sub-module `nco_sweep_step`: combinational next-word calculation (direction, add/sub, carry and borrow, clamp, end flag), so the clamp can be unit-tested in isolation.

## Test plan
- Up sweep: f_start=100, f_stop=130, f_step=10, dwell=2, single-shot.
  - `phase_inc` sequence: 100, 110, 120, 130, each held 3 cycles.
  - `done` pulses once; `busy` falls with it.
- Clamp: f_start=0, f_stop=25, f_step=10.
  - Sequence: 0, 10, 20, 25.
  - With f_start=0xFFFF_FFF0, f_stop=0xFFFF_FFFF, f_step=0x20: sequence 0xFFFF_FFF0, then 0xFFFF_FFFF, with no wrap to a small value.
- Down sweep and edge cases:
  - f_start=50, f_stop=20, f_step=15: sequence 50, 35, 20.
  - f_step=0: 50, then 20.
  - f_start=f_stop=7: single word 7.
- Abort at dwell midpoint of word 110 in the up-sweep case: next cycle `busy`=0, `phase_inc` stays 110, no `done`. A `start` in the same cycle is ignored.
- Loop: loop_en=1 with the up-sweep values.
  - Sawtooth build: 130 is followed by 100, and `done` never pulses.
  - Triangle build: sequence ..., 120, 130, 120, 110, 100, 110, ...
- Reset: assert `rst_n`=0 mid-dwell; all outputs are 0 in the same cycle. Release, then `start`: `f_start` appears at T+2.
